// File: rtl/vgapll_ctrl_pkg.sv
// Shared definitions for the VGA pixel-clock PLL lock/reset sequencer.
// The state encodings are visible to software through the debug state port.
package vgapll_ctrl_pkg;

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAITLK = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  // Width of the shared timer. It must hold (largest bound - 1) and is never narrower than 1 bit.
  function automatic int cntWidth(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/vgapll_ctrl_sync_2ff.sv
// Two-flop synchroniser that brings the asynchronous PLL locked flag into the refclk domain.
// Both flops clear on the synchronous reset, so the lock is seen as low until proven high.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vgapll_ctrl.sv
// Lock/reset sequencer for the 50 MHz -> 106.5 MHz VGA pixel-clock PLL.
// It pulses the PLL reset, qualifies lock, retries on timeout and gates the pixel-domain reset.
module vgapll_ctrl
  import vgapll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       pll_ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_o
);

  localparam int TW = cntWidth(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

  logic          lk_s;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_rst_q, sys_rst_n_q, pll_ready_q, fault_q;

  sync_2ff u_lock_sync (
    .clk_i (refclk),
    .rst_ni(rst_n),
    .d_i   (pll_locked),
    .q_o   (lk_s)
  );

  // Every transition clears the timer, so it only ever counts within one state visit.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      S_PLLRST: begin
        if (timer_q == RST_LAST) begin
          state_d = S_WAITLK;
          timer_d = '0;
        end
      end
      S_WAITLK: begin
        if (relock_req) begin
          state_d = S_PLLRST;
          timer_d = '0;
          retry_d = '0;
        end else if (lk_s) begin
          state_d = S_STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d = '0;
          if (retry_q + 4'd1 == RETRY_MAX) begin
            state_d = S_FAULT;
            retry_d = RETRY_MAX;
          end else begin
            state_d = S_PLLRST;
            retry_d = retry_q + 4'd1;
          end
        end
      end
      S_STABLE: begin
        if (relock_req) begin
          state_d = S_PLLRST;
          timer_d = '0;
          retry_d = '0;
        end else if (!lk_s) begin
          state_d = S_WAITLK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = S_RUN;
          timer_d = '0;
          retry_d = '0;
        end
      end
      S_RUN: begin
        timer_d = '0;
        // A lock loss wins over a simultaneous relock request so the loss is still counted.
        if (!lk_s) begin
          state_d = S_PLLRST;
          retry_d = '0;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (relock_req) begin
          state_d = S_PLLRST;
          retry_d = '0;
        end
      end
      S_FAULT: begin
        timer_d = '0;
        if (relock_req) begin
          state_d = S_PLLRST;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_PLLRST;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= S_PLLRST;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      pll_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == S_PLLRST) || (state_d == S_FAULT);
      sys_rst_n_q <= (state_d == S_RUN);
      pll_ready_q <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign pll_ready = pll_ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_vgapll_ctrl.sv
// Self-checking bench for vgapll_ctrl: directed sequencing scenarios plus random stimulus,
// every cycle compared against a behavioural model of the lock sequencing rules.
module tb_vgapll_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 3;

  localparam int PLLRST = 0;
  localparam int WAITLK = 1;
  localparam int STABLE = 2;
  localparam int RUN    = 3;
  localparam int FAULT  = 4;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       pll_ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state_o;

  int checkCount = 0;
  int failCount = 0;

  // Reference model: current phase, cycles spent in it, counters, and the lock flag history.
  int mState = PLLRST;
  int mElapsed = 0;
  int mRetry = 0;
  int mLoss = 0;
  bit lkPipe[$] = '{1'b0, 1'b0};

  always #10 refclk = ~refclk;

  vgapll_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .pll_ready (pll_ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state_o   (state_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advances the model across one refclk edge given the inputs that edge samples.
  function automatic void modelStep(input bit lk, input bit rq, input bit rn);
    int nxt;
    bit lkS;
    if (!rn) begin
      mState = PLLRST;
      mElapsed = 0;
      mRetry = 0;
      mLoss = 0;
      lkPipe = '{1'b0, 1'b0};
      return;
    end
    lkS = lkPipe[0];
    nxt = mState;
    mElapsed++;
    case (mState)
      PLLRST: if (mElapsed == RST_CYCLES) nxt = WAITLK;
      WAITLK: begin
        if (rq) begin
          nxt = PLLRST; mRetry = 0;
        end else if (lkS) begin
          nxt = STABLE;
        end else if (mElapsed == LOCK_TIMEOUT) begin
          if (mRetry + 1 == MAX_RETRIES) begin
            mRetry = MAX_RETRIES; nxt = FAULT;
          end else begin
            mRetry = mRetry + 1; nxt = PLLRST;
          end
        end
      end
      STABLE: begin
        if (rq) begin
          nxt = PLLRST; mRetry = 0;
        end else if (!lkS) begin
          nxt = WAITLK;
        end else if (mElapsed == STABLE_CYCLES) begin
          nxt = RUN; mRetry = 0;
        end
      end
      RUN: begin
        if (!lkS) begin
          nxt = PLLRST;
          mLoss = (mLoss < 255) ? mLoss + 1 : 255;
        end else if (rq) begin
          nxt = PLLRST;
        end
      end
      default: if (rq) begin
        nxt = PLLRST; mRetry = 0;
      end
    endcase
    if (nxt != mState) mElapsed = 0;
    mState = nxt;
    void'(lkPipe.pop_front());
    lkPipe.push_back(lk);
  endfunction

  task automatic checkModel();
    checkOutput("state", state_o, mState);
    checkOutput("pll_rst", pll_rst, (mState == PLLRST) || (mState == FAULT));
    checkOutput("sys_rst_n", sys_rst_n, mState == RUN);
    checkOutput("pll_ready", pll_ready, mState == RUN);
    checkOutput("fault", fault, mState == FAULT);
    checkOutput("retry_cnt", retry_cnt, mRetry);
    checkOutput("loss_cnt", loss_cnt, mLoss);
  endtask

  // Drives one cycle of inputs, lets the edge happen, then compares on the falling edge.
  task automatic applyStimulus(input bit lk, input bit rq, input bit rn);
    pll_locked = lk;
    relock_req = rq;
    rst_n = rn;
    @(posedge refclk);
    modelStep(lk, rq, rn);
    @(negedge refclk);
    checkModel();
  endtask

  // Holds the lock low until the PLL reset drops, then high until the downstream reset releases.
  task automatic sequenceToRun(input string tag, output int edgesToRelease);
    int n;
    n = 0;
    while (pll_rst && n < 100) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      n++;
    end
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      n++;
    end while (!sys_rst_n && n < 100);
    edgesToRelease = n;
    checkOutput(tag, sys_rst_n, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int n;
    int width;
    int gap;
    int w;
    bit prevRst;
    bit sawWait;
    bit lkLevel;
    int widths[$];
    int gaps[$];
    int retries[$];

    @(negedge refclk);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset_pll_rst", pll_rst, 1'b1);
    checkOutput("reset_sys_rst_n", sys_rst_n, 1'b0);
    checkOutput("reset_state", state_o, PLLRST);

    // Nominal bring-up
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      n++;
    end while (pll_rst && n < 50);
    checkOutput("nom_rst_width", n, RST_CYCLES);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      n++;
    end while (!sys_rst_n && n < 100);
    checkOutput("nom_release_latency", n, 2 + STABLE_CYCLES + 1);
    checkOutput("nom_ready", pll_ready, 1'b1);
    checkOutput("nom_retry", retry_cnt, 0);

    // Lock never returns after a relock: retries then fault
    applyStimulus(1'b0, 1'b1, 1'b1);
    width = 1;
    gap = 0;
    n = 0;
    while (!fault && n < 300) begin
      prevRst = pll_rst;
      applyStimulus(1'b0, 1'b0, 1'b1);
      n++;
      if (pll_rst) begin
        if (!prevRst) begin
          gaps.push_back(gap);
          retries.push_back(int'(retry_cnt));
          width = 0;
        end
        width++;
      end else begin
        if (prevRst) begin
          widths.push_back(width);
          gap = 0;
        end
        gap++;
      end
    end
    checkOutput("to_fault", fault, 1'b1);
    checkOutput("to_pulse_count", widths.size(), MAX_RETRIES);
    foreach (widths[i]) checkOutput("to_pulse_width", widths[i], RST_CYCLES);
    checkOutput("to_gap_count", gaps.size(), MAX_RETRIES);
    foreach (gaps[i]) checkOutput("to_gap_len", gaps[i], LOCK_TIMEOUT);
    foreach (retries[i]) checkOutput("to_retry_seq", retries[i], i + 1);
    checkOutput("to_retry_final", retry_cnt, MAX_RETRIES);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("fault_holds_rst", pll_rst, 1'b1);

    // Relock from fault, then recover
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("flt_relock_state", state_o, PLLRST);
    checkOutput("flt_relock_retry", retry_cnt, 0);
    checkOutput("flt_relock_fault", fault, 1'b0);
    sequenceToRun("flt_recover_run", n);

    // Relock from run, then a one-cycle glitch while stabilising
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("run_relock_state", state_o, PLLRST);
    checkOutput("run_relock_loss", loss_cnt, 0);
    while (pll_rst) applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    sawWait = 1'b0;
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      n++;
      if (state_o == 3'(WAITLK)) sawWait = 1'b1;
    end while (!sys_rst_n && n < 100);
    checkOutput("glitch_back_to_wait", sawWait, 1'b1);
    checkOutput("glitch_fresh_count", n, 2 + STABLE_CYCLES + 1);
    checkOutput("glitch_retry", retry_cnt, 0);

    // Lock loss in run
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      n++;
    end while (sys_rst_n && n < 20);
    checkOutput("loss_latency_ok", n <= 4, 1'b1);
    checkOutput("loss_cnt_first", loss_cnt, 1);
    sequenceToRun("loss_recover_run", n);

    // Relock request in the same cycle the loss is seen
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("loss_relock_state", state_o, PLLRST);
    checkOutput("loss_relock_cnt", loss_cnt, 2);
    sequenceToRun("loss_relock_run", n);

    // Many losses to reach saturation
    for (int i = 0; i < 300; i++) begin
      w = int'($urandom_range(1, 6));
      repeat (w) applyStimulus(1'b0, 1'b0, 1'b1);
      n = 0;
      while (sys_rst_n && n < 10) begin
        applyStimulus(1'b1, 1'b0, 1'b1);
        n++;
      end
      while (!sys_rst_n && n < 80) begin
        applyStimulus(1'b1, 1'b0, 1'b1);
        n++;
      end
    end
    checkOutput("loss_saturated", loss_cnt, 255);
    checkOutput("loss_sat_run", sys_rst_n, 1'b1);

    // Board reset while stabilising
    applyStimulus(1'b0, 1'b0, 1'b1);
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      n++;
    end while (state_o != 3'(STABLE) && n < 40);
    checkOutput("rst_reached_stable", state_o, STABLE);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rst_mid_state", state_o, PLLRST);
    checkOutput("rst_mid_pll_rst", pll_rst, 1'b1);
    checkOutput("rst_mid_sys_rst_n", sys_rst_n, 1'b0);
    checkOutput("rst_mid_loss", loss_cnt, 0);
    checkOutput("rst_mid_retry", retry_cnt, 0);

    // Random traffic against the model
    lkLevel = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) lkLevel = ~lkLevel;
      applyStimulus(lkLevel, $urandom_range(0, 39) == 0, $urandom_range(0, 199) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
